// File: rtl/mips_pkg.sv
// mips_pkg: shared widths, NOP word, fetch fault codes and instruction-memory FSM states.
package mips_pkg;

    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        FLT_OK       = 2'b00,
        FLT_MISALIGN = 2'b01,
        FLT_RANGE    = 2'b10
    } flt_t;

    typedef enum logic {
        RUN  = 1'b0,
        LOAD = 1'b1
    } imem_state_t;

endpackage

// File: rtl/imem_loader.sv
// imem_loader: RUN/LOAD control for run-time program loading into the instruction memory.
//  clk, rst        clock, asynchronous active-high reset
//  ld_start_i      enter LOAD from RUN and restart the write pointer
//  ld_valid_i      write the current load word (honoured only in LOAD)
//  ld_last_i       current load word is the last one of the image
//  state_o         RUN or LOAD
//  wptr_o, we_o    memory write address and write enable
//  ld_ready_o      high while in LOAD
//  ld_done_o       one-cycle pulse after the final write
module imem_loader
    import mips_pkg::*;
#(
    parameter int DEPTH = 128,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld_start_i,
    input  logic          ld_valid_i,
    input  logic          ld_last_i,
    output imem_state_t   state_o,
    output logic [AW-1:0] wptr_o,
    output logic          we_o,
    output logic          ld_ready_o,
    output logic          ld_done_o
);

    imem_state_t   state_q;
    logic [AW-1:0] wptr_q;
    logic          done_q;

    assign state_o    = state_q;
    assign wptr_o     = wptr_q;
    assign we_o       = (state_q == LOAD) & ld_valid_i;
    assign ld_ready_o = state_q == LOAD;
    assign ld_done_o  = done_q;

    // Writing the top word ends the load even without ld_last, so the pointer never runs past the array.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            wptr_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == RUN) begin
                if (ld_start_i) begin
                    state_q <= LOAD;
                    wptr_q  <= '0;
                end
            end else if (ld_valid_i) begin
                wptr_q <= wptr_q + 1'b1;
                if (ld_last_i || wptr_q == AW'(DEPTH - 1)) begin
                    state_q <= RUN;
                    done_q  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/inst_mem_fetch.sv
// inst_mem_fetch: instruction memory with registered 1-cycle fetch, handshake, flush, faults and optional load port.
module inst_mem_fetch
  import mips_pkg::*;
#(
  parameter int                DATA_W    = INSTR_W,
  parameter int                DEPTH     = 128,
  parameter int                ADDR_W    = 32,
  parameter string             INIT_FILE = "",
  parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(NOP)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              flush,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_instr,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [1:0]        rsp_fault
`ifdef IMEM_LOAD_EN
  ,
  input  logic              ld_start,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_done
`endif
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  imem_state_t       state;
  logic              accept;
  logic              misaligned;
  logic              in_range;
  flt_t              fault_d;
  flt_t              fault_q;
  logic [DATA_W-1:0] instr_d;
  logic [DATA_W-1:0] instr_q;
  logic [ADDR_W-1:0] addr_q;
  logic              valid_d;
  logic              valid_q;
`ifdef IMEM_LOAD_EN
  logic [AW-1:0] wptr;
  logic          we;
  imem_loader #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_loader (
    .clk        (clk),
    .rst        (rst),
    .ld_start_i (ld_start),
    .ld_valid_i (ld_valid),
    .ld_last_i  (ld_last),
    .state_o    (state),
    .wptr_o     (wptr),
    .we_o       (we),
    .ld_ready_o (ld_ready),
    .ld_done_o  (ld_done)
  );
  always_ff @(posedge clk) begin
    if (we) mem[wptr] <= ld_data;
  end
`else
  assign state = RUN;
`endif
  assign req_ready  = (state == RUN) & ~flush & (~valid_q | rsp_ready);
  assign accept     = req_valid & req_ready;
  assign misaligned = |req_addr[1:0];
  assign in_range   = req_addr[ADDR_W-1:2] < (ADDR_W-2)'(DEPTH);
  always_comb begin
    fault_d = misaligned ? FLT_MISALIGN : (in_range ? FLT_OK : FLT_RANGE);
    instr_d = (fault_d == FLT_OK) ? mem[req_addr[AW+1:2]] : NOP_INSTR;
    valid_d = (state != RUN || flush) ? 1'b0 : (accept ? 1'b1 : valid_q & ~rsp_ready);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      addr_q  <= '0;
      fault_q <= FLT_OK;
    end else begin
      valid_q <= valid_d;
      if (accept) begin
        instr_q <= instr_d;
        addr_q  <= req_addr;
        fault_q <= fault_d;
      end
    end
  end
  assign rsp_valid = valid_q;
  assign rsp_instr = instr_q;
  assign rsp_addr  = addr_q;
  assign rsp_fault = fault_q;
endmodule

// File: tb/tb_inst_mem_fetch.sv
// tb_inst_mem_fetch: scoreboard bench for inst_mem_fetch (fetch, stall, faults, flush, optional loading).
module tb_inst_mem_fetch;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] addr;
        logic [1:0]  fault;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic        flush = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_instr;
    logic [31:0] rsp_addr;
    logic [1:0]  rsp_fault;
`ifdef IMEM_LOAD_EN
    logic        ld_start = 1'b0;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [31:0] ld_data = '0;
    logic        ld_last = 1'b0;
    logic        ld_done;
`endif

    int          tests = 0;
    int          fails = 0;
    logic [31:0] model [128];
    exp_t        sb [$];

    inst_mem_fetch dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .flush     (flush),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_instr (rsp_instr),
        .rsp_addr  (rsp_addr),
        .rsp_fault (rsp_fault)
`ifdef IMEM_LOAD_EN
        ,
        .ld_start  (ld_start),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_data   (ld_data),
        .ld_last   (ld_last),
        .ld_done   (ld_done)
`endif
    );

    always #5 clk = ~clk;

    function automatic exp_t expect_of(input logic [31:0] a);
        exp_t e;
        e.addr = a;
        if (a[1:0] != 2'b00) begin
            e.instr = 32'h0;
            e.fault = 2'b01;
        end else if (a[31:2] >= 30'd128) begin
            e.instr = 32'h0;
            e.fault = 2'b10;
        end else begin
            e.instr = model[a[8:2]];
            e.fault = 2'b00;
        end
        return e;
    endfunction

    // Inputs change #1 after posedge, so at negedge they hold what the next edge will sample.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && rsp_valid && rsp_ready) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL sb_pop: unexpected response addr=%h instr=%h", rsp_addr, rsp_instr);
            end else begin
                e = sb.pop_front();
                if (rsp_instr !== e.instr || rsp_addr !== e.addr || rsp_fault !== e.fault) begin
                    fails++;
                    $display("FAIL sb_rsp: got addr=%h instr=%h fault=%b, want addr=%h instr=%h fault=%b",
                             rsp_addr, rsp_instr, rsp_fault, e.addr, e.instr, e.fault);
                end
            end
        end else if (!rst && rsp_valid && flush && sb.size() != 0) begin
            void'(sb.pop_front());
        end
        if (!rst && req_valid && req_ready) sb.push_back(expect_of(req_addr));
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        repeat (2) tick();
        tests++;
        if (rsp_valid !== 1'b0 || rsp_instr !== 32'h0 || rsp_addr !== 32'h0 || rsp_fault !== 2'b00) begin
            fails++;
            $display("FAIL reset_outputs: got v=%b i=%h a=%h f=%b, want 0/0/0/00", rsp_valid, rsp_instr, rsp_addr, rsp_fault);
        end
        tests++;
        if (req_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_req_ready: got %b want 1", req_ready);
        end
`ifdef IMEM_LOAD_EN
        tests++;
        if (ld_ready !== 1'b0 || ld_done !== 1'b0) begin
            fails++;
            $display("FAIL reset_ld: got ld_ready=%b ld_done=%b want 0/0", ld_ready, ld_done);
        end
`endif
        rst = 1'b0;
        tick();
    endtask

`ifdef IMEM_LOAD_EN
    task automatic test_preload();
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        tests++;
        if (ld_ready !== 1'b1 || req_ready !== 1'b0) begin
            fails++;
            $display("FAIL preload_enter: got ld_ready=%b req_ready=%b want 1/0", ld_ready, req_ready);
        end
        for (int i = 0; i < 128; i++) begin
            ld_valid = 1'b1;
            ld_data  = model[i];
            tick();
        end
        ld_valid = 1'b0;
        tests++;
        if (ld_ready !== 1'b0 || ld_done !== 1'b1) begin
            fails++;
            $display("FAIL preload_autoexit: got ld_ready=%b ld_done=%b want 0/1", ld_ready, ld_done);
        end
        tick();
        tests++;
        if (ld_done !== 1'b0) begin
            fails++;
            $display("FAIL preload_done_pulse: got %b want 0", ld_done);
        end
    endtask

    task automatic test_load();
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            model[i] = 32'hAAAA0001 + 32'(i);
            ld_valid = 1'b1;
            ld_data  = model[i];
            ld_last  = (i == 2);
            tick();
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        tests++;
        if (ld_done !== 1'b1 || ld_ready !== 1'b0) begin
            fails++;
            $display("FAIL load_done: got ld_done=%b ld_ready=%b want 1/0", ld_done, ld_ready);
        end
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_addr = 32'(i * 4);
            tick();
            tests++;
            if (rsp_valid !== 1'b1 || rsp_instr !== model[i]) begin
                fails++;
                $display("FAIL load_fetch: got v=%b instr=%h want 1/%h", rsp_valid, rsp_instr, model[i]);
            end
        end
        drain();
    endtask

    task automatic test_reset_mid_load();
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            model[i] = 32'hBBBB0001 + 32'(i);
            ld_valid = 1'b1;
            ld_data  = model[i];
            tick();
        end
        ld_valid = 1'b0;
        rst = 1'b1;
        #1;
        tests++;
        if (ld_ready !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            fails++;
            $display("FAIL midload_reset: got ld_ready=%b rsp_valid=%b req_ready=%b want 0/0/1", ld_ready, rsp_valid, req_ready);
        end
        tick();
        rst = 1'b0;
        sb.delete();
        tick();
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req_addr = 32'(i * 4);
            tick();
            tests++;
            if (rsp_instr !== model[i]) begin
                fails++;
                $display("FAIL midload_fetch: got %h want %h", rsp_instr, model[i]);
            end
        end
        drain();
    endtask
`endif

    task automatic test_back_to_back();
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_addr  = 32'h0;
        tick();
        tests++;
        if (rsp_valid !== 1'b1 || rsp_instr !== model[0] || rsp_addr !== 32'h0) begin
            fails++;
            $display("FAIL b2b_first: got v=%b i=%h a=%h want 1/%h/0", rsp_valid, rsp_instr, rsp_addr, model[0]);
        end
        req_addr = 32'h4;
        tick();
        tests++;
        if (rsp_valid !== 1'b1 || rsp_instr !== model[1] || rsp_addr !== 32'h4) begin
            fails++;
            $display("FAIL b2b_second: got v=%b i=%h a=%h want 1/%h/4", rsp_valid, rsp_instr, rsp_addr, model[1]);
        end
        req_valid = 1'b0;
        tick();
        tests++;
        if (rsp_valid !== 1'b0) begin
            fails++;
            $display("FAIL b2b_idle: got rsp_valid=%b want 0", rsp_valid);
        end
    endtask

    task automatic test_stall();
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h8;
        tick();
        req_addr = 32'hC;
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (rsp_valid !== 1'b1 || rsp_instr !== model[2] || rsp_addr !== 32'h8 || req_ready !== 1'b0) begin
                fails++;
                $display("FAIL stall_hold: got v=%b i=%h a=%h rdy=%b want 1/%h/8/0", rsp_valid, rsp_instr, rsp_addr, req_ready, model[2]);
            end
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        tests++;
        if (req_ready !== 1'b1) begin
            fails++;
            $display("FAIL stall_release: got req_ready=%b want 1", req_ready);
        end
        tick();
        tests++;
        if (rsp_addr !== 32'hC || rsp_instr !== model[3]) begin
            fails++;
            $display("FAIL stall_next: got a=%h i=%h want c/%h", rsp_addr, rsp_instr, model[3]);
        end
        drain();
    endtask

    task automatic test_faults();
        logic [31:0] addrs [6] = '{32'h6, 32'h200, 32'h202, 32'h1FC, 32'h7, 32'hFFFF_FFFC};
        exp_t        e;
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        foreach (addrs[i]) begin
            req_addr = addrs[i];
            e = expect_of(addrs[i]);
            tick();
            tests++;
            if (rsp_fault !== e.fault || rsp_instr !== e.instr) begin
                fails++;
                $display("FAIL fault_%0d: addr=%h got f=%b i=%h want f=%b i=%h", i, addrs[i], rsp_fault, rsp_instr, e.fault, e.instr);
            end
        end
        drain();
    endtask

    task automatic test_flush();
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h10;
        tick();
        flush    = 1'b1;
        req_addr = 32'h14;
        #1;
        tests++;
        if (rsp_valid !== 1'b1 || req_ready !== 1'b0) begin
            fails++;
            $display("FAIL flush_pre: got v=%b rdy=%b want 1/0", rsp_valid, req_ready);
        end
        tick();
        flush     = 1'b0;
        req_valid = 1'b0;
        tests++;
        if (rsp_valid !== 1'b0) begin
            fails++;
            $display("FAIL flush_drop: got rsp_valid=%b want 0", rsp_valid);
        end
        tick();
        tests++;
        if (rsp_valid !== 1'b0 || rsp_addr !== 32'h10) begin
            fails++;
            $display("FAIL flush_no_accept: got v=%b a=%h want 0/10", rsp_valid, rsp_addr);
        end
        drain();
    endtask

    initial begin
        model[0] = 32'h20080020;
        model[1] = 32'h20090037;
        for (int i = 2; i < 128; i++) model[i] = $urandom;
`ifndef IMEM_LOAD_EN
        for (int i = 0; i < 128; i++) dut.mem[i] = model[i];
`endif
        test_reset();
`ifdef IMEM_LOAD_EN
        test_preload();
`endif
        test_back_to_back();
        test_stall();
        test_faults();
        test_flush();
`ifdef IMEM_LOAD_EN
        test_load();
        test_reset_mid_load();
`endif
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL sb_leftover: got %0d pending entries want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
